// File: rtl/fw_ram_writer_gmax.sv
`default_nettype none
// ============================================================================
//  Module   : fw_ram_writer_gmax
//  Purpose  : Streams decimated-spectrum magnitudes (unsigned Q64.16) into the
//             shared fw_real RAM at bins 0..NBINS-1. While it writes, it tracks
//             the in-range global maximum (gmax) and its bin (gmax_bin), then
//             pulses donefw for the downstream NLP post-processor.
//  Options  : FW_READBACK_EN - after the frame, read back the RAM word at
//             gmax_bin and flag rb_err if it differs from gmax.
//  Revision : 1.0 - initial release
// ============================================================================
module fw_ram_writer_gmax #(
  parameter int N1      = 80,
  parameter int NBINS   = 256,
  parameter int MIN_BIN = 16,
  parameter int MAX_BIN = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          startfw,
  input  logic          in_valid,
  input  logic [N1-1:0] in_fw,
  input  logic [N1-1:0] q_fw_real,
  output logic [9:0]    addr_fw_real,
  output logic [N1-1:0] d_fw_real,
  output logic          wren_fw_real,
  output logic [N1-1:0] gmax,
  output logic [9:0]    gmax_bin,
  output logic          busy,
  output logic          donefw,
  output logic          rb_err
);

  // Bin-index constants, sized to the 10-bit counter.
  localparam logic [9:0] C_LAST_BIN = 10'(NBINS - 1);
  localparam logic [9:0] C_MIN_BIN  = 10'(MIN_BIN);
  localparam logic [9:0] C_MAX_BIN  = 10'(MAX_BIN);

  // Frame sequencer states.
  localparam logic [2:0] C_ST_IDLE     = 3'd0;
  localparam logic [2:0] C_ST_WRITE    = 3'd1;
  localparam logic [2:0] C_ST_FINISH   = 3'd2;
  localparam logic [2:0] C_ST_DONE     = 3'd3;
`ifdef FW_READBACK_EN
  localparam logic [2:0] C_ST_RB_ADDR  = 3'd4;
  localparam logic [2:0] C_ST_RB_WAIT1 = 3'd5;
  localparam logic [2:0] C_ST_RB_WAIT2 = 3'd6;
  localparam logic [2:0] C_ST_RB_CHECK = 3'd7;
`endif

  logic [2:0]    state_q,    state_d;
  logic [9:0]    cnt_q,      cnt_d;
  logic [9:0]    addr_q,     addr_d;
  logic [N1-1:0] wdata_q,    wdata_d;
  logic          wren_q,     wren_d;
  logic [N1-1:0] gmax_q,     gmax_d;
  logic [9:0]    gmax_bin_q, gmax_bin_d;
  logic          busy_q,     busy_d;
  logic          donefw_q,   donefw_d;
`ifdef FW_READBACK_EN
  logic          rb_err_q,   rb_err_d;
`endif

  logic w_in_range;

  assign w_in_range = (cnt_q >= C_MIN_BIN) && (cnt_q <= C_MAX_BIN);

  // Next-state, RAM-port and max-tracking logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wren_d     = 1'b0;
    gmax_d     = gmax_q;
    gmax_bin_d = gmax_bin_q;
    busy_d     = busy_q;
    donefw_d   = 1'b0;
`ifdef FW_READBACK_EN
    rb_err_d   = rb_err_q;
`endif

    case (state_q)
      C_ST_IDLE: begin
        if (startfw) begin
          state_d    = C_ST_WRITE;
          cnt_d      = 10'd0;
          gmax_d     = '0;
          gmax_bin_d = C_MIN_BIN;
          busy_d     = 1'b1;
`ifdef FW_READBACK_EN
          rb_err_d   = 1'b0;
`endif
        end
      end

      C_ST_WRITE: begin
        if (in_valid) begin
          addr_d  = cnt_q;
          wdata_d = in_fw;
          wren_d  = 1'b1;
          // Strict compare keeps the lowest bin on ties.
          if (w_in_range && (in_fw > gmax_q)) begin
            gmax_d     = in_fw;
            gmax_bin_d = cnt_q;
          end
          cnt_d = cnt_q + 10'd1;
          if (cnt_q == C_LAST_BIN) begin
            state_d = C_ST_FINISH;
          end
        end
      end

      C_ST_FINISH: begin
`ifdef FW_READBACK_EN
        // Present gmax_bin and hold it through the RAM read latency.
        addr_d  = gmax_bin_q;
        state_d = C_ST_RB_ADDR;
`else
        state_d = C_ST_DONE;
`endif
      end

`ifdef FW_READBACK_EN
      C_ST_RB_ADDR:  state_d = C_ST_RB_WAIT1;
      C_ST_RB_WAIT1: state_d = C_ST_RB_WAIT2;
      C_ST_RB_WAIT2: state_d = C_ST_RB_CHECK;
      C_ST_RB_CHECK: begin
        rb_err_d = (q_fw_real != gmax_q);
        state_d  = C_ST_DONE;
      end
`endif

      C_ST_DONE: begin
        donefw_d = 1'b1;
        busy_d   = 1'b0;
        state_d  = C_ST_IDLE;
      end

      default: state_d = C_ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= C_ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wren_q     <= 1'b0;
      gmax_q     <= '0;
      gmax_bin_q <= '0;
      busy_q     <= 1'b0;
      donefw_q   <= 1'b0;
`ifdef FW_READBACK_EN
      rb_err_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wren_q     <= wren_d;
      gmax_q     <= gmax_d;
      gmax_bin_q <= gmax_bin_d;
      busy_q     <= busy_d;
      donefw_q   <= donefw_d;
`ifdef FW_READBACK_EN
      rb_err_q   <= rb_err_d;
`endif
    end
  end

  assign addr_fw_real = addr_q;
  assign d_fw_real    = wdata_q;
  assign wren_fw_real = wren_q;
  assign gmax         = gmax_q;
  assign gmax_bin     = gmax_bin_q;
  assign busy         = busy_q;
  assign donefw       = donefw_q;

`ifdef FW_READBACK_EN
  assign rb_err = rb_err_q;
`else
  // Read data is only consumed by the readback check.
  logic w_unused_q_fw_real;
  assign w_unused_q_fw_real = ^q_fw_real;
  assign rb_err             = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fw_ram_writer_gmax.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fw_ram_writer_gmax
//  Purpose  : Self-checking bench for fw_ram_writer_gmax. Directed and random
//             frames are compared against a frame-level reference (max search
//             over the in-range bins, expected write list, latency, RAM image).
//             Honours FW_READBACK_EN for latency and rb_err expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fw_ram_writer_gmax;

  localparam int N1      = 80;
  localparam int NBINS   = 256;
  localparam int MIN_BIN = 16;
  localparam int MAX_BIN = 128;
`ifdef FW_READBACK_EN
  localparam int C_LAT = 7;
`else
  localparam int C_LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          startfw = 1'b0;
  logic          in_valid = 1'b0;
  logic [N1-1:0] in_fw = '0;
  logic [N1-1:0] q_fw_real;
  logic [9:0]    addr_fw_real;
  logic [N1-1:0] d_fw_real;
  logic          wren_fw_real;
  logic [N1-1:0] gmax;
  logic [9:0]    gmax_bin;
  logic          busy;
  logic          donefw;
  logic          rb_err;

  fw_ram_writer_gmax #(
    .N1(N1), .NBINS(NBINS), .MIN_BIN(MIN_BIN), .MAX_BIN(MAX_BIN)
  ) dut (
    .clk(clk), .rst(rst), .startfw(startfw), .in_valid(in_valid),
    .in_fw(in_fw), .q_fw_real(q_fw_real), .addr_fw_real(addr_fw_real),
    .d_fw_real(d_fw_real), .wren_fw_real(wren_fw_real), .gmax(gmax),
    .gmax_bin(gmax_bin), .busy(busy), .donefw(donefw), .rb_err(rb_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [N1-1:0] got,
                          input logic [N1-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // RAM model: 2-cycle read latency, optional corruption of one word on read.
  logic [N1-1:0] mem [1024];
  logic [N1-1:0] rd1, rd2;
  logic [9:0]    ra1, ra2;
  bit            corrupt = 1'b0;
  logic [9:0]    corrupt_bin = '0;

  always @(posedge clk) begin
    if (wren_fw_real) mem[addr_fw_real] <= d_fw_real;
    rd1 <= mem[addr_fw_real];
    ra1 <= addr_fw_real;
    rd2 <= rd1;
    ra2 <= ra1;
  end
  assign q_fw_real = (corrupt && (ra2 == corrupt_bin)) ? (rd2 ^ 80'h1) : rd2;

  // Expected write stream; every observed write must match its head.
  typedef struct { logic [9:0] addr; logic [N1-1:0] data; } wr_t;
  wr_t exp_q[$];

  always @(negedge clk) begin
    if (wren_fw_real) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_wr", 80'(wren_fw_real), 80'h0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check_eq("wr_addr", 80'(addr_fw_real), 80'(e.addr));
        check_eq("wr_data", d_fw_real, e.data);
      end
    end
  end

  logic [N1-1:0] smp [NBINS];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_samples(input int pat);
    logic [95:0] t;
    for (int i = 0; i < NBINS; i++) begin
      case (pat)
        0: smp[i] = 80'(i) << 16;
        1: smp[i] = (i == 10 || i == 200) ? (80'h7FFF << 16) : (80'h1 << 16);
        2: smp[i] = (i == 40 || i == 60) ? (80'h5 << 16) : 80'h0;
        3: smp[i] = 80'h0;
        4: smp[i] = 80'($urandom_range(0, 5)) << 16;
        default: begin
          t = {$urandom, $urandom, $urandom};
          smp[i] = t[79:0];
        end
      endcase
    end
  endtask

  // Reference: largest in-range value, then the first bin holding it.
  task automatic ref_max(output logic [N1-1:0] gm, output logic [9:0] gb);
    gm = '0;
    for (int i = MIN_BIN; i <= MAX_BIN; i++)
      if (smp[i] > gm) gm = smp[i];
    gb = 10'(MIN_BIN);
    for (int i = MAX_BIN; i >= MIN_BIN; i--)
      if (smp[i] == gm) gb = 10'(i);
  endtask

  // gap: 0 back-to-back, 1 every other cycle, 2 random gaps.
  task automatic run_frame(input int pat, input int gap, input bit extra_start,
                           input bit post_valid, input bit bad_rb);
    logic [N1-1:0] gm;
    logic [9:0]    gb;
    int            t_last;
    int            bad;
    bit            seen;
    fill_samples(pat);
    ref_max(gm, gb);
    corrupt     = bad_rb;
    corrupt_bin = gb;
    // Strobes before acceptance must be ignored.
    in_valid = 1'b1;
    in_fw    = 80'hDEAD;
    step();
    in_valid = 1'b0;
    startfw  = 1'b1;
    step();
    startfw  = 1'b0;
    check_eq("busy_after_start", 80'(busy), 80'h1);
    t_last = cyc;
    for (int i = 0; i < NBINS; i++) begin
      if (gap == 1 || (gap == 2 && $urandom_range(0, 3) == 0)) begin
        in_valid = 1'b0;
        for (int g = 0; g < ((gap == 2) ? int'($urandom_range(1, 2)) : 1); g++) step();
      end
      in_valid = 1'b1;
      in_fw    = smp[i];
      startfw  = extra_start && (i == 50);
      exp_q.push_back('{addr: 10'(i), data: smp[i]});
      t_last = cyc;
      step();
      startfw = 1'b0;
      if (extra_start && i == 50) check_eq("busy_extra_start", 80'(busy), 80'h1);
    end
    in_valid = post_valid;
    in_fw    = 80'hBAD;
    seen     = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (donefw) seen = 1'b1;
      else step();
    end
    check_eq("done_seen", 80'(seen), 80'h1);
    check_eq("done_latency", 80'(cyc - t_last), 80'(C_LAT));
    check_eq("gmax", gmax, gm);
    check_eq("gmax_bin", 80'(gmax_bin), 80'(gb));
    check_eq("busy_at_done", 80'(busy), 80'h0);
`ifdef FW_READBACK_EN
    check_eq("rb_err", 80'(rb_err), 80'(bad_rb));
`else
    check_eq("rb_err", 80'(rb_err), 80'h0);
`endif
    in_valid = 1'b0;
    step();
    check_eq("done_one_cycle", 80'(donefw), 80'h0);
    check_eq("gmax_hold", gmax, gm);
    check_eq("writes_left", 80'(exp_q.size()), 80'h0);
    bad = 0;
    for (int i = 0; i < NBINS; i++)
      if (mem[i] !== smp[i]) bad++;
    check_eq("ram_image", 80'(bad), 80'h0);
    corrupt = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "_gmax"}, gmax, 80'h0);
    check_eq({tag, "_gmax_bin"}, 80'(gmax_bin), 80'h0);
    check_eq({tag, "_busy"}, 80'(busy), 80'h0);
    check_eq({tag, "_wren"}, 80'(wren_fw_real), 80'h0);
    check_eq({tag, "_addr"}, 80'(addr_fw_real), 80'h0);
    check_eq({tag, "_data"}, d_fw_real, 80'h0);
    check_eq({tag, "_donefw"}, 80'(donefw), 80'h0);
    check_eq({tag, "_rb_err"}, 80'(rb_err), 80'h0);
  endtask

  // Reset arrives after 100 samples of a frame.
  task automatic rst_mid_frame();
    fill_samples(0);
    startfw = 1'b1;
    step();
    startfw = 1'b0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_fw    = smp[i];
      exp_q.push_back('{addr: 10'(i), data: smp[i]});
      step();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    check_cleared("rst_mid");
    check_eq("rst_mid_writes_left", 80'(exp_q.size()), 80'h0);
    step();
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_cleared("reset");
    step();
    run_frame(0, 0, 1'b0, 1'b0, 1'b0);  // ramp: peak at bin 128
    run_frame(1, 0, 1'b0, 1'b1, 1'b0);  // big values out of range only
    run_frame(2, 0, 1'b0, 1'b0, 1'b0);  // equal peaks, lowest bin wins
    run_frame(3, 0, 1'b0, 1'b0, 1'b0);  // all zero
    run_frame(4, 1, 1'b1, 1'b0, 1'b0);  // alternating strobes, extra start
    rst_mid_frame();
    run_frame(0, 0, 1'b0, 1'b0, 1'b0);  // counter restarts at bin 0
    run_frame(4, 2, 1'b0, 1'b1, 1'b0);
    run_frame(5, 2, 1'b1, 1'b0, 1'b0);
    run_frame(5, 0, 1'b0, 1'b0, 1'b0);
`ifdef FW_READBACK_EN
    run_frame(5, 0, 1'b0, 1'b0, 1'b1);  // corrupted readback word
    run_frame(0, 1, 1'b0, 1'b0, 1'b0);  // rb_err clears on next frame
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
